// File: rtl/spi_ram_arb_pkg.sv
// Shared types and constants for the two-port SPI RAM arbiter.
package spi_ram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/spi_ram_arb_pick.sv
// Combinational winner selection between the fetch and data ports.
// Build option SPI_RAM_ARB_RR_EN selects round-robin instead of fixed priority.
module spi_ram_arb_pick
  import spi_ram_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef SPI_RAM_ARB_RR_EN
  input  logic       last_id,
`endif
  output logic       valid,
  output logic       id
);

  always_comb begin
    valid = |req;
    id    = PORT_FETCH;
`ifdef SPI_RAM_ARB_RR_EN
    // On contention the port that was not served last goes next.
    if (req == 2'b11) begin
      id = ~last_id;
    end else if (req[PORT_DATA]) begin
      id = PORT_DATA;
    end
`else
    if (req[PORT_DATA]) begin
      id = PORT_DATA;
    end
`endif
  end

endmodule

// File: rtl/spi_ram_arb.sv
// Two-port arbiter/sequencer in front of the shared SPI RAM controller.
// Define SPI_RAM_ARB_RR_EN for round-robin arbitration; default is data-port priority.
module spi_ram_arb
  import spi_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [DATA_BITS-1:0] wdata0,
  input  logic [DATA_BITS-1:0] wdata1,
  output logic [1:0]           done,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 busy,
  output logic                 gnt_id,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_wdata,
  output logic                 ram_start_read,
  output logic                 ram_start_write,
  input  logic [DATA_BITS-1:0] ram_rdata,
  input  logic                 ram_busy
);

  arb_state_e           state_q, state_d;
  logic                 write_q;
  logic                 gnt_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic                 pick_valid;
  logic                 pick_id;

`ifdef SPI_RAM_ARB_RR_EN
  logic last_q;
`endif

  spi_ram_arb_pick u_pick (
    .req     (req),
`ifdef SPI_RAM_ARB_RR_EN
    .last_id (last_q),
`endif
    .valid   (pick_valid),
    .id      (pick_id)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      // Controller raises busy on the edge that registers the start pulse.
      StWait:  if (!ram_busy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      gnt_q   <= PORT_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SPI_RAM_ARB_RR_EN
      last_q  <= PORT_FETCH;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && pick_valid) begin
        gnt_q   <= pick_id;
        write_q <= we[pick_id];
        addr_q  <= pick_id ? addr1 : addr0;
        wdata_q <= pick_id ? wdata1 : wdata0;
      end
      if (state_q == StWait && !ram_busy) begin
        if (!write_q) begin
          rdata_q <= ram_rdata;
        end
`ifdef SPI_RAM_ARB_RR_EN
        last_q <= gnt_q;
`endif
      end
    end
  end

  always_comb begin
    done            = 2'b00;
    done[gnt_q]     = (state_q == StDone);
    busy            = (state_q != StIdle);
    ram_start_read  = (state_q == StIssue) && !write_q;
    ram_start_write = (state_q == StIssue) && write_q;
  end

  assign rdata     = rdata_q;
  assign gnt_id    = gnt_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: doc/spi_ram_arb.md
# spi_ram_arb

Two-port arbiter and sequencer for the shared `spi_ram_controller`, used by the CPU's instruction-fetch path and its data load/store path. It accepts word-wide read/write requests from both ports, grants one at a time, and drives the controller's one-cycle start pulses. It waits out the controller's busy period and returns read data with a single-cycle done pulse to the granted port. It sits between the CPU core's sequencer and the SPI RAM controller instance.

## Interface

**Parameters**
- `ADDR_BITS`, default 16: width of word address.
- `DATA_BITS`, default 16: width of data word (controller `DATA_WIDTH_BYTES` × 8).

**Ports**
- `clk` — in, 1: sole clock, rising edge.
- `rst` — in, 1: reset, synchronous, active-high. Parent drives the controller's `rstn` with `~rst`.
- `req[1:0]` — in, 2: request per port. Port 0 is fetch, port 1 is data.
- `we[1:0]` — in, 2: per-port write enable (1 = write, 0 = read).
- `addr0`, `addr1` — in, ADDR_BITS each: per-port address.
- `wdata0`, `wdata1` — in, DATA_BITS each: per-port write data.
- `done[1:0]` — out, 2: one-cycle completion pulse to the served port.
- `rdata` — out, DATA_BITS: read data. Valid while `done` is high; held until the next read completes.
- `busy` — out, 1: arbiter is not in IDLE.
- `gnt_id` — out, 1: port currently being served. Meaningful only while `busy` is high.
- `ram_addr` — out, ADDR_BITS: to controller `addr_in`.
- `ram_wdata` — out, DATA_BITS: to controller `data_in`.
- `ram_start_read`, `ram_start_write` — out, 1 each: controller start pulses.
- `ram_rdata` — in, DATA_BITS: from controller `data_out`.
- `ram_busy` — in, 1: from controller `busy`.

## Operation

- **States:** IDLE, ISSUE, WAIT, DONE. All outputs are registered or decoded from registered state.
- **IDLE**
  - If any `req` bit is high, pick a winner, then latch its `addr`, `wdata`, `we` and the winner id into `ram_addr`, `ram_wdata`, the write flag and `gnt_id`. Go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - Assert `ram_start_write` if the write flag is set, otherwise `ram_start_read`. Never assert both.
  - Go to WAIT.
- **WAIT**
  - Hold `ram_addr` and `ram_wdata` stable.
  - When `ram_busy` is low: if the transaction is a read, capture `ram_rdata` into `rdata`. Go to DONE.
- **DONE** (exactly 1 cycle)
  - `done[gnt_id]` is high. Go to IDLE.
- **Requester contract**
  - `req`, `addr`, `we`, `wdata` are sampled only in IDLE.
  - A requester may drop `req` before it is granted; there is no penalty.
  - After `done`, a requester that keeps `req` high is treated as issuing a new transaction with whatever fields are present in the following IDLE cycle.
- **Arbitration without macro:** fixed priority; port 1 (data) wins over port 0.
- **Simultaneous events:** a request arriving while the arbiter is busy waits. No request is lost and none is queued beyond the level-held `req`.
- **Reset mid-transaction:** return to IDLE and drop any start pulse. `done` is not emitted for the aborted access. The controller is reset in the same cycle through `rstn`.

## Timing

- **Reset values:** state IDLE, `done` = 0, `rdata` = 0, `busy` = 0, `gnt_id` = 0, `ram_addr` = 0, `ram_wdata` = 0, both start lines 0.
- **Latency:** `req` sampled at edge N → ISSUE in cycle N+1 → WAIT from N+2. If `ram_busy` is already low at the first WAIT sample, DONE is in cycle N+3. Minimum request-to-done latency is 3 cycles plus the controller's busy length.
- **Busy check:** `ram_busy` is not examined in ISSUE. The controller raises busy on the edge that registers the start pulse.
- **Throughput:** back-to-back transactions are separated by one IDLE cycle.

## Configuration

- **`SPI_RAM_ARB_RR_EN` defined:** round-robin arbitration.
  - A `last_id` register (reset 0) records the most recently served port.
  - When both ports request in IDLE, the port ≠ `last_id` wins.
  - `last_id` updates on entering DONE.
- **Not defined:** fixed priority as above. No `last_id` register is built.

## Structure

- **Package `spi_ram_arb_pkg`:** state enumeration (IDLE, ISSUE, WAIT, DONE) and port-index constants (PORT_FETCH = 0, PORT_DATA = 1).
- **Sub-module `spi_ram_arb_pick`:** combinational winner selection from `req` and, when `SPI_RAM_ARB_RR_EN` is defined, `last_id`. Keeping it separate isolates the macro-dependent logic.

## Test plan

- **Single read:** port 0 read of 0x0010; controller model returns 0xBEEF after 4 busy cycles → `ram_start_read` pulses for 1 cycle with `ram_addr` = 0x0010. `done[0]` pulses with `rdata` = 0xBEEF, 3 + 4 cycles after `req`.
- **Single write:** port 1 write of 0x1234 to 0x0020 → `ram_start_write` pulses once with `ram_wdata` = 0x1234. `done[1]` pulses. `rdata` is unchanged.
- **Contention, fixed priority:** both ports request in the same cycle → port 1 is served first, then port 0. Two `done` pulses, in that order.
- **Contention, round-robin (`SPI_RAM_ARB_RR_EN`):** both ports hold `req` high for 4 transactions → grants alternate 1, 0, 1, 0.
- **Reset mid-WAIT:** assert `rst` during WAIT → next cycle is IDLE with every output at its reset value, and no `done` pulse.
- **Held request:** port 0 keeps `req` high after `done` with the address changed to 0x0011 → second transaction uses 0x0011, after exactly one IDLE cycle.
